// File: rtl/shape_gen_pkg.sv
// Shared mode codes and state encoding for the shape generator.
package shape_gen_pkg;

  localparam logic [1:0] MODE_RHOMB_C = 2'd0;
  localparam logic [1:0] MODE_TRI_C   = 2'd1;
  localparam logic [1:0] MODE_SAW_C   = 2'd2;
  localparam logic [1:0] MODE_SQR_C   = 2'd3;

  typedef enum logic [1:0] {
    MODE_RHOMB = MODE_RHOMB_C,
    MODE_TRI   = MODE_TRI_C,
    MODE_SAW   = MODE_SAW_C,
    MODE_SQR   = MODE_SQR_C
  } mode_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/shape_gen_map.sv
// Combinational phase-to-sample map; zero latency, no flow control.
// All arithmetic is modulo 2^W, which is exact because every result fits W bits.
module shape_gen_map
  import shape_gen_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [1:0]   mode,
  input  logic         sel,
  input  logic [W-1:0] a,
  output logic [W-1:0] sample
);

  localparam logic [W-1:0] P_H   = W'(2**(W-1));
  localparam logic [W-1:0] P_M   = W'(2**W - 1);
  localparam logic [W-1:0] P_3H2 = W'(3 * 2**(W-1) - 2);

  logic         w_lo;
  logic [W-1:0] w_a2;
  logic [W-1:0] w_res;

  assign w_lo = ~a[W-1];
  assign w_a2 = {a[W-2:0], 1'b0};

  always_comb begin
    w_res = '0;
    case (mode)
      MODE_RHOMB_C: begin
        if (!sel) w_res = w_lo ? (P_H - a) : (a - P_H);
        else      w_res = w_lo ? (a + P_H) : (P_3H2 - a);
      end
      // 2M+1-2a reduces to M-2a modulo 2^W
      MODE_TRI_C: w_res = w_lo ? w_a2 : (P_M - w_a2);
      MODE_SAW_C: w_res = a;
      MODE_SQR_C: w_res = w_lo ? '0 : P_M;
      default:    w_res = '0;
    endcase
  end

  assign sample = w_res;

endmodule

// File: rtl/shape_gen.sv
// Phase-accumulator waveform generator; sample registered one cycle after start/accept.
// Holds all state and outputs while out_valid=1 and out_ready=0.
module shape_gen
  import shape_gen_pkg::*;
#(
  parameter int W  = 8,
  parameter int PW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic [1:0]    mode,
  input  logic [PW-1:0] step,
  input  logic          out_ready,
  output logic          out_valid,
  output logic [W-1:0]  out,
  output logic          out_sel,
  output logic          period_start
);

  state_e        r_state;
  state_e        w_state_nxt;
  logic [PW-1:0] r_acc;
  logic [PW-1:0] r_step_q;
  logic [1:0]    r_mode_q;
  logic          r_sel;
  logic [W-1:0]  r_out;
  logic          r_out_sel;
  logic          r_period_start;

  logic          w_out_valid;
  logic          w_idle;
  logic          w_accept;
  logic          w_advance;
  logic          w_carry;
  logic [PW-1:0] w_sum;
  logic [PW-1:0] w_acc_nxt;
  logic          w_wrap;
  logic          w_sel_nxt;
  logic [1:0]    w_mode_nxt;
  logic [1:0]    w_map_mode;
  logic          w_map_sel;
  logic [W-1:0]  w_map_a;
  logic [W-1:0]  w_sample;

  assign w_idle   = (r_state == S_IDLE);
  assign w_accept = w_out_valid & out_ready;

  // A rhomboid pair shares one phase, so only the sel=1 accept advances (and can wrap)
  assign w_advance        = (r_mode_q != MODE_RHOMB_C) | r_sel;
  assign {w_carry, w_sum} = {1'b0, r_acc} + {1'b0, r_step_q};
  assign w_acc_nxt        = w_advance ? w_sum : r_acc;
  assign w_wrap           = w_advance & w_carry;
  assign w_sel_nxt        = (r_mode_q == MODE_RHOMB_C) & ~r_sel;
  assign w_mode_nxt       = w_wrap ? mode : r_mode_q;

  assign w_map_mode = w_idle ? mode : w_mode_nxt;
  assign w_map_sel  = w_idle ? 1'b0 : w_sel_nxt;
  assign w_map_a    = w_idle ? '0 : w_acc_nxt[PW-1 -: W];

  shape_gen_map #(.W(W)) u_map (
    .mode   (w_map_mode),
    .sel    (w_map_sel),
    .a      (w_map_a),
    .sample (w_sample)
  );

  always_ff @(posedge clk) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (en) w_state_nxt = S_RUN;
      S_RUN:   if (w_accept && !en) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_out_valid = (r_state == S_RUN);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_acc          <= '0;
      r_sel          <= 1'b0;
      r_mode_q       <= MODE_RHOMB_C;
      r_step_q       <= '0;
      r_out          <= '0;
      r_out_sel      <= 1'b0;
      r_period_start <= 1'b0;
    end else if (w_idle) begin
      r_mode_q <= mode;
      r_step_q <= step;
      if (en) begin
        r_acc          <= '0;
        r_sel          <= 1'b0;
        r_out          <= w_sample;
        r_out_sel      <= 1'b0;
        r_period_start <= 1'b1;
      end
    end else if (w_accept) begin
      r_acc          <= w_acc_nxt;
      r_sel          <= w_sel_nxt;
      r_out          <= w_sample;
      r_out_sel      <= w_sel_nxt;
      r_period_start <= w_wrap;
      if (w_wrap) begin
        r_mode_q <= mode;
        r_step_q <= step;
      end
    end
  end

  assign out_valid    = w_out_valid;
  assign out          = r_out;
  assign out_sel      = r_out_sel;
  assign period_start = r_period_start;

endmodule
